gate_exerciser: RTL
===================

# gate_exerciser

Self-checking stimulus stage that sits directly upstream of a combinational gate under test (e.g. `and2`). It drives every input combination in ascending binary order and holds each one for a programmable settle time. It samples the gate's output, compares it against a reference model of the selected gate function, and reports pass/fail, a saturating mismatch count and the first failing vector. It replaces free-running hand-written stimulus counters in lab benches with one reusable, synthesizable block.

## Interface
Parameters:
- `WIDTH`, 2, number of gate inputs (1..8)
- `SETTLE`, 0, extra cycles each vector is held before sampling (0..15)
- `CNT_W`, 8, width of mismatch counter

Ports:
- `clk` in 1, rising-edge clock
- `rst_n` in 1, reset, asynchronous, active-low
- `start` in 1, begin a sweep (single-cycle pulse or level)
- `func` in 3, expected gate function, latched on accepted start
- `gate_out` in 1, observed output of gate under test
- `vec` out WIDTH, drives gate inputs
- `busy` out 1, sweep in progress
- `done` out 1, sweep finished, sticky until next accepted start or reset
- `pass` out 1, valid while `done`; 1 iff `err_count`==0
- `err_count` out CNT_W, mismatches, saturates at 2^CNT_W−1
- `first_fail` out WIDTH, vector of first mismatch
- `first_fail_valid` out 1, at least one mismatch recorded

## Operation
- func codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR (reductions over all `vec` bits), 6 BUF (`vec[0]`), 7 NOT (`~vec[0]`).
- States: IDLE, RUN, DONE.
- IDLE/DONE + `start`=1 → RUN:
  - `vec`←0, settle counter←`SETTLE`, `err_count`/`first_fail`/`first_fail_valid`/`done`/`pass`←0, `func` latched.
- RUN, counter≠0 → decrement.
- RUN, counter==0 → sample `gate_out` and compare with the model of (`vec`, latched func).
  - On mismatch: `err_count`+1 (saturating). If `first_fail_valid`==0, `first_fail`←`vec` and `first_fail_valid`←1.
  - If `vec`==all-ones → DONE and `done`←1. `pass` reflects the final count including this sample.
  - Otherwise `vec`←`vec`+1 and counter←`SETTLE`.
- `start` in RUN is ignored. `func` changes after acceptance are ignored.
- DONE holds `vec` at all-ones and all results stable.
- `busy`=1 exactly in RUN.

## Timing
- Reset values: `vec`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail`=0, `first_fail_valid`=0, state IDLE.
- Reset asserted mid-sweep clears everything immediately (asynchronously). A new `start` is then required.
- Accepted `start` at edge E0: vector k is applied from edge E0+k·(SETTLE+1) and sampled at edge E0+(k+1)·(SETTLE+1).
- `done` rises after edge E0+2^WIDTH·(SETTLE+1), the same edge that samples the final vector. `busy` falls at that edge.
- `gate_out` must be stable SETTLE+1 cycles after `vec` changes. The gate under test is combinational.
- Results are registered with no output latency beyond the sample edge.

## Structure
- Shared include `gate_defs.vh`: func code constants (`FN_AND`..`FN_NOT`) and state encodings. The include is reused by other lab benches.
- Sub-module `gate_ref_model`: combinational, inputs `vec`[WIDTH] and `func`[3], output `expected`.
- All sequencing, counters and result registers stay in `gate_exerciser`.

## Test plan
- WIDTH=2, SETTLE=0, func=0, connected to `and2`, start at E0:
  - `vec` steps 00, 01, 10, 11.
  - `done`=1 after E0+4.
  - `pass`=1, `err_count`=0, `first_fail_valid`=0.
- Same setup, func=1 (OR) against `and2`:
  - Mismatches at 01 and 10.
  - `err_count`=2, `first_fail`=01, `pass`=0.
- SETTLE=2, func=0, `and2`:
  - Each vector held 3 cycles, `done` after E0+12, `busy` high for exactly 12 cycles.
- WIDTH=3, CNT_W=2, `gate_out` tied opposite to the model (func=5, `gate_out`=~XNOR):
  - All 8 samples mismatch.
  - `err_count` saturates at 3, `first_fail`=000.
- Reset mid-sweep: pull `rst_n` low while `vec`=10.
  - All outputs go to 0 without a clock edge.
  - After release, state stays IDLE until `start`.
- Start handling:
  - `start` pulsed during RUN: no restart, and sweep timing is unchanged.
  - `start` in DONE after a failing run: counters clear and a fresh sweep against `and2` with func=0 ends with `pass`=1.

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the gate exerciser: gate function codes and sequencer states.
package gate_exerciser_pkg;

    localparam logic [2:0] FN_AND  = 3'd0;
    localparam logic [2:0] FN_OR   = 3'd1;
    localparam logic [2:0] FN_XOR  = 3'd2;
    localparam logic [2:0] FN_NAND = 3'd3;
    localparam logic [2:0] FN_NOR  = 3'd4;
    localparam logic [2:0] FN_XNOR = 3'd5;
    localparam logic [2:0] FN_BUF  = 3'd6;
    localparam logic [2:0] FN_NOT  = 3'd7;

    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate under test: what the selected function yields for vec.
module gate_ref_model
    import gate_exerciser_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [2:0]       func,
    output logic             expected
);

    always_comb begin
        expected = 1'b0;
        case (func)
            FN_AND:  expected = &vec;
            FN_OR:   expected = |vec;
            FN_XOR:  expected = ^vec;
            FN_NAND: expected = ~&vec;
            FN_NOR:  expected = ~|vec;
            FN_XNOR: expected = ~^vec;
            FN_BUF:  expected = vec[0];
            FN_NOT:  expected = ~vec[0];
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps every input vector of a combinational gate in ascending order, holds each for
// SETTLE extra cycles, and compares the sampled gate output against the reference model.
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic             gate_out,
    output logic [WIDTH-1:0] vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] first_fail,
    output logic             first_fail_valid,
    output state_t           dbg_state
);

    localparam logic [SETTLE_W-1:0] SETTLE_CNT = SETTLE_W'(SETTLE);

    state_t              state_q, state_d;
    logic                accept, sample, expected, mismatch, last_vec;
    logic [SETTLE_W-1:0] cnt_q;
    logic [2:0]          func_q;
    logic [WIDTH-1:0]    vec_q, ff_q;
    logic [CNT_W-1:0]    err_q;
    logic                ffv_q, done_q;

    gate_ref_model #(.WIDTH(WIDTH)) u_ref (
        .vec      (vec_q),
        .func     (func_q),
        .expected (expected)
    );

    assign mismatch = gate_out != expected;
    assign last_vec = vec_q == '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    accept  = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    sample = 1'b1;
                    if (last_vec) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            cnt_q  <= '0;
            func_q <= '0;
            err_q  <= '0;
            ff_q   <= '0;
            ffv_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (accept) begin
            vec_q  <= '0;
            cnt_q  <= SETTLE_CNT;
            func_q <= func;
            err_q  <= '0;
            ff_q   <= '0;
            ffv_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (sample) begin
            if (mismatch) begin
                if (err_q != '1) err_q <= err_q + 1'b1;
                if (!ffv_q) begin
                    ff_q  <= vec_q;
                    ffv_q <= 1'b1;
                end
            end
            // The final vector stays on the gate inputs once the sweep completes.
            if (last_vec) begin
                done_q <= 1'b1;
            end else begin
                vec_q <= vec_q + 1'b1;
                cnt_q <= SETTLE_CNT;
            end
        end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign vec              = vec_q;
    assign busy             = state_q == ST_RUN;
    assign done             = done_q;
    assign pass             = done_q && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;
    assign dbg_state        = state_q;

endmodule
